// File: rtl/qadd_tree_pipe_if.sv
// qadd_tree_pipe_if: valid/ready streaming bundle for the sign-magnitude adder tree.
//   in_valid/in_ready/in_data   : operand vector, lane i at in_data[i*W +: W]
//   out_valid/out_ready/out_data: sign-magnitude sum
//   out_ovf                     : exact sum magnitude did not fit in W-1 bits
// Modports: master drives operands and accepts results; slave is the adder tree.
interface qadd_tree_pipe_if #(
  parameter int unsigned FP_WORD_LENGTH = 11,
  parameter int unsigned NUM_INPUTS     = 9
) ();
  logic                                 in_valid;
  logic                                 in_ready;
  logic [NUM_INPUTS*FP_WORD_LENGTH-1:0] in_data;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [FP_WORD_LENGTH-1:0]            out_data;
  logic                                 out_ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/qadd_tree_pipe.sv
// qadd_tree_pipe: pipelined sign-magnitude adder tree. Sums NUM_INPUTS operands per
// transaction at one vector per cycle, with exact wide internal arithmetic, -0
// normalisation, and optional saturation of the final result.
//   S_AXI_ACLK    : clock, rising edge
//   S_AXI_ARESETN : asynchronous active-low reset
//   bus (slave)   : in_valid/in_ready/in_data operand stream,
//                   out_valid/out_ready/out_data/out_ovf result stream
// Pipeline: one register stage of normalised operands, then clog2(NUM_INPUTS) tree
// stages; the last tree stage also applies saturation/wrap and drives the outputs.
module qadd_tree_pipe #(
  parameter int unsigned FP_WORD_LENGTH = 11,
  parameter int unsigned FP_FRAC_LENGTH = 0,
  parameter int unsigned NUM_INPUTS     = 9,
  parameter bit          SATURATE       = 1'b1
) (
  input logic             S_AXI_ACLK,
  input logic             S_AXI_ARESETN,
  qadd_tree_pipe_if.slave bus
);

  localparam int unsigned W      = FP_WORD_LENGTH;
  localparam int unsigned Levels = $clog2(NUM_INPUTS);
  // Wide enough that no intermediate sum can overflow.
  localparam int unsigned Mw     = W - 1 + Levels;

  typedef logic [Mw-1:0] mag_t;

  localparam mag_t MaxMag = {{Levels{1'b0}}, {(W-1){1'b1}}};

  // Number of live elements entering tree level s.
  function automatic int unsigned lvl_cnt(input int unsigned s);
    int unsigned n = NUM_INPUTS;
    for (int unsigned i = 0; i < s; i++) n = (n + 1) / 2;
    return n;
  endfunction

  function automatic logic [Mw:0] sm_add(input logic sa, input mag_t ma,
                                         input logic sb, input mag_t mb);
    logic s;
    mag_t m;
    if (sa == sb) begin
      m = ma + mb;
      s = sa;
    end else if (ma >= mb) begin
      m = ma - mb;
      s = sa;
    end else begin
      m = mb - ma;
      s = sb;
    end
    if (m == '0) s = 1'b0;
    return {s, m};
  endfunction

  logic adv;
  logic nrm_sgn   [NUM_INPUTS];
  mag_t nrm_mag   [NUM_INPUTS];
  // st_*_q[0] holds normalised operands; st_*_q[s] holds the output of tree level s-1.
  logic st_sgn_q  [Levels][NUM_INPUTS];
  mag_t st_mag_q  [Levels][NUM_INPUTS];
  logic nxt_sgn   [Levels][NUM_INPUTS];
  mag_t nxt_mag   [Levels][NUM_INPUTS];
  logic [Levels:0] vld_q;
  logic            fin_ovf;
  logic            res_sgn;
  logic [W-2:0]    res_mag;
  logic [W-1:0]    out_data_q;
  logic            out_ovf_q;

  assign adv           = !vld_q[Levels] || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_q[Levels];
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;

  // A zero-magnitude lane is +0 regardless of its sign bit.
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_in
    assign nrm_mag[i] = {{Levels{1'b0}}, bus.in_data[i*W +: W-1]};
    assign nrm_sgn[i] = bus.in_data[i*W + W-1] && (bus.in_data[i*W +: W-1] != '0);
  end

  for (genvar s = 0; s < Levels; s++) begin : g_lvl
    localparam int unsigned CntIn  = lvl_cnt(s);
    localparam int unsigned CntOut = lvl_cnt(s + 1);
    for (genvar j = 0; j < NUM_INPUTS; j++) begin : g_el
      if (j < CntOut && 2*j + 1 < CntIn) begin : g_pair
        assign {nxt_sgn[s][j], nxt_mag[s][j]} =
            sm_add(st_sgn_q[s][2*j], st_mag_q[s][2*j],
                   st_sgn_q[s][2*j+1], st_mag_q[s][2*j+1]);
      end else if (j < CntOut) begin : g_pass
        // Odd trailing element rides through this level unchanged.
        assign nxt_sgn[s][j] = st_sgn_q[s][2*j];
        assign nxt_mag[s][j] = st_mag_q[s][2*j];
      end else begin : g_idle
        assign nxt_sgn[s][j] = 1'b0;
        assign nxt_mag[s][j] = '0;
      end
    end
  end

  always_comb begin
    fin_ovf = nxt_mag[Levels-1][0] > MaxMag;
    res_mag = nxt_mag[Levels-1][0][W-2:0];
    res_sgn = nxt_sgn[Levels-1][0];
    if (SATURATE) begin
      if (fin_ovf) res_mag = MaxMag[W-2:0];
    end else begin
      // Wrapping can land exactly on zero; keep that +0.
      if (res_mag == '0) res_sgn = 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      vld_q      <= '0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
      for (int s = 0; s < int'(Levels); s++) begin
        for (int i = 0; i < int'(NUM_INPUTS); i++) begin
          st_sgn_q[s][i] <= 1'b0;
          st_mag_q[s][i] <= '0;
        end
      end
    end else if (adv) begin
      vld_q[0] <= bus.in_valid;
      for (int s = 1; s <= int'(Levels); s++) vld_q[s] <= vld_q[s-1];
      for (int i = 0; i < int'(NUM_INPUTS); i++) begin
        st_sgn_q[0][i] <= nrm_sgn[i];
        st_mag_q[0][i] <= nrm_mag[i];
      end
      for (int s = 1; s < int'(Levels); s++) begin
        for (int i = 0; i < int'(NUM_INPUTS); i++) begin
          st_sgn_q[s][i] <= nxt_sgn[s-1][i];
          st_mag_q[s][i] <= nxt_mag[s-1][i];
        end
      end
      out_data_q <= {res_sgn, res_mag};
      out_ovf_q  <= fin_ovf;
    end
  end

endmodule

// File: doc/qadd_tree_pipe.md
Name: qadd_tree_pipe

Overview:
- Pipelined, parametrised sign-magnitude fixed-point adder tree. Sums NUM_INPUTS operands per transaction and returns one sign-magnitude result with optional saturation and an overflow flag.
- Sits after the 3x3 convolution multipliers and reduces the nine tap products to a single pixel value.
- Replaces chains of single-stage combinational sign-magnitude adders. Adds a valid/ready handshake, exact wide internal arithmetic, and -0 normalisation.

Parameters:
- FP_WORD_LENGTH, 11: operand/result width; MSB = sign, [W-2:0] = magnitude.
- FP_FRAC_LENGTH, 0: fractional bits. Informational only; the binary point is identical on all inputs, so there is no effect on the addition.
- NUM_INPUTS, 9: operands per transaction, >= 2.
- SATURATE, 1: 1 = clamp magnitude on overflow; 0 = wrap (drop high magnitude bits).

Ports:
- S_AXI_ACLK  input  1  clock; all logic rising-edge.
- S_AXI_ARESETN  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data holds a valid operand vector.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  NUM_INPUTS*FP_WORD_LENGTH  lane i at [i*W +: W], sign-magnitude.
- out_valid  output  1  out_data/out_ovf valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  FP_WORD_LENGTH  sign-magnitude sum.
- out_ovf  output  1  sum magnitude exceeded 2^(W-1)-1 for this result.

Behaviour:
- Definitions:
  - W = FP_WORD_LENGTH.
  - LEVELS = clog2(NUM_INPUTS); 4 for 9 inputs.
  - MAXMAG = 2^(W-1)-1.
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_ovf=0.
  - All stage valid bits cleared; all in-flight data is discarded.
  - in_ready=1 once reset is released.
- Handshake and stall:
  - adv = !out_valid | out_ready; in_ready = adv (combinational).
  - Transfer in on in_valid & in_ready; transfer out on out_valid & out_ready.
  - When adv=0, every stage register, its valid bit, and the outputs hold.
  - No loss, duplication or reordering. Bubbles are not compressed.
- Latency: a vector accepted at edge k produces out_valid=1 after edge k+LEVELS, provided adv stays 1. Throughput is 1 vector/cycle.
- Input stage: each lane with zero magnitude is forced to +0 (an input of 0x400 for W=11 counts as +0).
- Tree stages:
  - Stage s pairs adjacent elements; an odd trailing element is registered through unchanged.
  - Internal magnitude width is W-1+LEVELS, so no intermediate overflow is possible and the arithmetic is exact.
- Pair add rule (sign-magnitude):
  - Same signs: magnitudes add; sign kept.
  - Different signs: larger magnitude minus smaller; sign taken from the larger operand.
  - Equal magnitudes or zero result: sign forced to 0.
- Output stage, applied in the last register stage:
  - ovf = (exact magnitude > MAXMAG).
  - SATURATE=1: magnitude = ovf ? MAXMAG : exact; sign preserved.
  - SATURATE=0: magnitude = exact[W-2:0]. If the truncated magnitude is 0, the sign is forced to 0.
  - out_ovf is per-result, not sticky.
- Simultaneous in/out transfer in the same cycle is legal and required at full rate.
- Reset during a stall or with a full pipeline: outputs go to reset values immediately (async); nothing in flight is emitted afterwards.

Test Plan:
- W=11, NUM_INPUTS=9, all lanes +5 (0x005), out_ready=1 -> out_valid exactly 4 cycles after accept; out_data=0x02D (+45), out_ovf=0.
- Lane0 +100 (0x064), lane1 -30 (0x41E), others 0 -> 0x046 (+70). Lane0 +7, lane1 -7 -> 0x000. All lanes 0x400 -> 0x000, never 0x400.
- Overflow cases:
  - All lanes +200 -> 0x3FF, out_ovf=1.
  - All lanes -200 -> 0x7FF, out_ovf=1.
  - Rerun with SATURATE=0: +1800 -> 0x308, out_ovf=1.
  - +1000,+1000,-1000, rest 0 -> 0x3E8, out_ovf=0 (exact internal, no intermediate clamp).
- Six back-to-back vectors (sums 1..6); drop out_ready for 3 cycles while result 2 is presented:
  - in_ready=0 during the stall; out_data holds 0x002.
  - Results then arrive in order 1..6, each exactly once.
- Accept 3 vectors, then assert S_AXI_ARESETN=0 for 1 cycle:
  - out_valid=0 and out_data=0 immediately.
  - After release, with no new input, out_valid stays 0 for 10 cycles.
- NUM_INPUTS=2 and NUM_INPUTS=5 builds with random sign-magnitude vectors vs. a reference model -> bit-exact outputs, latency 1 and 3 respectively.
